barrier_unit: RTL
=================

Name: barrier_unit

Overview:
- Consumes the barrier request issued by the GPU unit: barrier id, expected warp count minus one, and issuing warp id.
- Tracks per-barrier arrival counts and waiting-warp masks.
- Holds arriving warps stalled toward the warp scheduler, then releases them together when the final warp of the group arrives.
- Sits between the GPU-unit commit path and the warp scheduler's stall/activate logic.

Parameters:
- NUM_WARPS, 4, number of hardware warps (power of two, ≥2)
- NUM_BARRIERS, 4, number of barrier slots (power of two, ≥1)
- NW_BITS, $clog2(NUM_WARPS), warp-id / size field width
- NB_BITS, $clog2(NUM_BARRIERS) (min 1), barrier-id width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- barrier_valid  in  1  barrier request present
- barrier_id  in  NB_BITS  target barrier slot
- barrier_size_m1  in  NW_BITS  participating warps minus one
- barrier_wid  in  NW_BITS  issuing warp
- barrier_ready  out  1  request accepted this cycle when high with valid
- stall_mask  out  NUM_WARPS  warps currently held at any barrier
- release_valid  out  1  one-cycle pulse: a barrier completed
- release_id  out  NB_BITS  completed barrier slot
- release_wmask  out  NUM_WARPS  warps to reactivate, including the final arriver
- size_err  out  1  one-cycle pulse: arrival size_m1 differs from latched size
- busy  out  1  any barrier slot holds waiting warps

Behaviour:
- Reset (asserted low, asynchronous): all per-slot count, mask and size registers clear to 0.
  - Outputs clear to 0: stall_mask, release_valid, release_id, release_wmask, size_err.
  - Holds regardless of in-flight arrivals; partially filled barriers are discarded.
- barrier_ready = ~stall_mask[barrier_wid], combinational. A stalled warp cannot re-arrive.
- Accept = barrier_valid & barrier_ready. At most one accept per cycle, so at most one release per cycle.
- Per slot b state: cnt[b] (NW_BITS), mask[b] (NUM_WARPS), size[b] (NW_BITS), active[b] = |mask[b].
- On accept at edge N, with id=b and w=barrier_wid, the effective size is:
  - barrier_size_m1 if slot b is not active (latched into size[b]);
  - size[b] otherwise.
- Completion case (cnt[b] == effective size):
  - Edge N: release_valid=1, release_id=b, release_wmask = mask[b] | (1<<w).
  - Edge N: cnt[b] and mask[b] cleared; stall bits of mask[b] cleared in stall_mask.
  - Warp w is never stalled.
- Otherwise:
  - cnt[b]++, mask[b] |= 1<<w, stall_mask[w] set at edge N.
  - release_valid=0 at N unless set by another event (none possible).
- size_m1 = 0 on an idle slot means immediate release: release_wmask = 1<<w, no stall.
- size_err pulses at edge N when slot b is active and barrier_size_m1 != size[b]. The arrival still proceeds using size[b].
- All outputs are registered. Latency from accept to stall/release visibility is exactly 1 cycle.
- release_valid, release_wmask and size_err are 0 in any cycle without a corresponding event.
- Counter wrap cannot occur: cnt ≤ size ≤ NUM_WARPS-1 fits in NW_BITS.
- Slots are independent: arrivals to slot a never alter slot b state.
- A slot reused after release starts fresh and latches a new size.
- busy = |stall_mask, registered.
- Arrival with barrier_valid while !barrier_ready is ignored; no state changes.

Test Plan:
- Reset mid-operation: slot 1 holds warps 0,2 → assert reset low → stall_mask=0, busy=0; next arrival on slot 1 with size_m1=0 releases immediately.
- Basic 4-warp barrier: id=0, size_m1=3, warps 0,1,2 arrive on cycles 1-3 → stall_mask=0b0111 after cycle 3. Warp 3 arrives cycle 5 → cycle 6 shows release_valid=1, release_id=0, release_wmask=0b1111, stall_mask=0.
- Immediate release: idle slot 2, size_m1=0, wid=1 → next cycle release_valid=1, release_wmask=0b0010, stall_mask unchanged (0).
- Stalled re-arrival: warp 0 waiting on slot 0 (size_m1=1); present barrier_valid with wid=0 → barrier_ready=0, no state change. Warp 2 arrives → release_wmask=0b0101.
- Interleaved slots: slot 0 size_m1=1 gets warp 0, slot 1 size_m1=1 gets warp 1, then warp 2→slot 1, then warp 3→slot 0 → releases in order: (id 1, 0b0110), then (id 0, 0b1001). stall_mask=0 at end.
- Size mismatch: slot 3 latched size_m1=2 by warp 0; warp 1 arrives with size_m1=1 → size_err pulses one cycle, cnt advances, no release. Warp 2 arrives → release_wmask=0b0111.

Source files
------------

// File: rtl/barrier_unit_if.sv
// Barrier request channel between the GPU-unit commit path and the barrier unit.
//   barrier_valid   : request present (master -> slave)
//   barrier_id      : target barrier slot (master -> slave)
//   barrier_size_m1 : participating warps minus one (master -> slave)
//   barrier_wid     : issuing warp (master -> slave)
//   barrier_ready   : request accepted when high with valid (slave -> master)
interface barrier_unit_if #(
  parameter int unsigned NUM_WARPS    = 4,
  parameter int unsigned NUM_BARRIERS = 4,
  parameter int unsigned NW_BITS      = $clog2(NUM_WARPS),
  parameter int unsigned NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
);
  logic               barrier_valid;
  logic [NB_BITS-1:0] barrier_id;
  logic [NW_BITS-1:0] barrier_size_m1;
  logic [NW_BITS-1:0] barrier_wid;
  logic               barrier_ready;

  modport master (
    output barrier_valid,
    output barrier_id,
    output barrier_size_m1,
    output barrier_wid,
    input  barrier_ready
  );

  modport slave (
    input  barrier_valid,
    input  barrier_id,
    input  barrier_size_m1,
    input  barrier_wid,
    output barrier_ready
  );
endinterface

// File: rtl/barrier_unit.sv
// Warp barrier unit. Collects arrivals per barrier slot, holds arriving warps stalled
// and releases the whole group when the final warp of the group arrives.
//   clk           : clock, all state on rising edge
//   reset         : asynchronous active-low reset
//   req           : barrier request channel (slave side)
//   stall_mask    : warps currently held at any barrier (registered)
//   release_valid : one-cycle pulse, a barrier completed
//   release_id    : completed barrier slot
//   release_wmask : warps to reactivate, including the final arriver
//   size_err      : one-cycle pulse, arrival size differs from latched size
//   busy          : any warp waiting at any barrier (registered)
module barrier_unit #(
  parameter int unsigned NUM_WARPS    = 4,
  parameter int unsigned NUM_BARRIERS = 4,
  parameter int unsigned NW_BITS      = $clog2(NUM_WARPS),
  parameter int unsigned NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  barrier_unit_if.slave        req,
  output logic [NUM_WARPS-1:0] stall_mask,
  output logic                 release_valid,
  output logic [NB_BITS-1:0]   release_id,
  output logic [NUM_WARPS-1:0] release_wmask,
  output logic                 size_err,
  output logic                 busy
);

  // Folds an out-of-range id onto slot 0 when there is only a single slot.
  localparam logic [NB_BITS-1:0] SlotMask = NB_BITS'(NUM_BARRIERS - 1);

  logic [NUM_BARRIERS-1:0][NW_BITS-1:0]   cnt_q, cnt_d;
  logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0] mask_q, mask_d;
  logic [NUM_BARRIERS-1:0][NW_BITS-1:0]   size_q, size_d;
  logic [NUM_WARPS-1:0]                   stall_mask_q, stall_mask_d;
  logic                                   release_valid_q, release_valid_d;
  logic [NB_BITS-1:0]                     release_id_q, release_id_d;
  logic [NUM_WARPS-1:0]                   release_wmask_q, release_wmask_d;
  logic                                   size_err_q, size_err_d;
  logic                                   busy_q, busy_d;

  logic                 accept;
  logic [NB_BITS-1:0]   slot;
  logic                 slot_active;
  logic [NW_BITS-1:0]   eff_size;
  logic [NUM_WARPS-1:0] wbit;

  // A warp already held at a barrier cannot arrive again.
  assign req.barrier_ready = ~stall_mask_q[req.barrier_wid];
  assign accept            = req.barrier_valid & req.barrier_ready;
  assign slot              = req.barrier_id & SlotMask;
  assign slot_active       = |mask_q[slot];
  assign eff_size          = slot_active ? size_q[slot] : req.barrier_size_m1;
  assign wbit              = NUM_WARPS'(1) << req.barrier_wid;

  always_comb begin
    cnt_d           = cnt_q;
    mask_d          = mask_q;
    size_d          = size_q;
    stall_mask_d    = stall_mask_q;
    release_valid_d = 1'b0;
    release_id_d    = release_id_q;
    release_wmask_d = '0;
    size_err_d      = 1'b0;

    if (accept) begin
      if (!slot_active) begin
        size_d[slot] = req.barrier_size_m1;
      end else if (req.barrier_size_m1 != size_q[slot]) begin
        size_err_d = 1'b1;
      end

      if (cnt_q[slot] == eff_size) begin
        // Final arriver: release the group; the arriving warp itself never stalls.
        release_valid_d = 1'b1;
        release_id_d    = slot;
        release_wmask_d = mask_q[slot] | wbit;
        cnt_d[slot]     = '0;
        mask_d[slot]    = '0;
        stall_mask_d    = stall_mask_q & ~mask_q[slot];
      end else begin
        cnt_d[slot]  = cnt_q[slot] + NW_BITS'(1);
        mask_d[slot] = mask_q[slot] | wbit;
        stall_mask_d = stall_mask_q | wbit;
      end
    end

    busy_d = |stall_mask_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q           <= '0;
      mask_q          <= '0;
      size_q          <= '0;
      stall_mask_q    <= '0;
      release_valid_q <= 1'b0;
      release_id_q    <= '0;
      release_wmask_q <= '0;
      size_err_q      <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      mask_q          <= mask_d;
      size_q          <= size_d;
      stall_mask_q    <= stall_mask_d;
      release_valid_q <= release_valid_d;
      release_id_q    <= release_id_d;
      release_wmask_q <= release_wmask_d;
      size_err_q      <= size_err_d;
      busy_q          <= busy_d;
    end
  end

  assign stall_mask    = stall_mask_q;
  assign release_valid = release_valid_q;
  assign release_id    = release_id_q;
  assign release_wmask = release_wmask_q;
  assign size_err      = size_err_q;
  assign busy          = busy_q;

endmodule
